// File: rtl/keypad_pkg.sv
// Shared keypad definitions: FSM states, idle row pattern, column drive table and decode helpers.
package keypad_pkg;

  localparam int unsigned ROW_W = 4;
  localparam int unsigned COL_W = 4;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned VAL_W = 32;
  localparam int unsigned CODE_W = 4;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_RELEASE  = 2'd2
  } state_e;

  localparam logic [ROW_W-1:0] ROW_IDLE = 4'b1111;
  localparam logic [COL_W-1:0] COL_OFF  = 4'b1111;

  // One-cold column drive indexed by column number (entry 0 drives column 0 low).
  localparam logic [3:0][COL_W-1:0] COL_TBL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // True when exactly one row line is pulled low.
  function automatic logic single_low(input logic [ROW_W-1:0] rows);
    logic [ROW_W-1:0] act;
    act = ~rows;
    return (act != 4'b0000) && ((act & (act - 4'd1)) == 4'b0000);
  endfunction

  // Index of the lowest-numbered row line that is low.
  function automatic logic [1:0] low_index(input logic [ROW_W-1:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of asynchronous level signals.
module sync_2ff #(
  parameter int unsigned         WIDTH   = 4,
  parameter logic [WIDTH-1:0]    RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Next values: first stage captures the pin, second stage resolves metastability.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer registers, reset to the idle level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with debounce, single-shot key accept and 8-digit hex entry register.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter logic [31:0] SCAN_CNT     = 32'h20000,
  parameter logic [31:0] DEBOUNCE_CNT = 32'h100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  input  logic        clr,
  output logic [3:0]  col,
  output logic [31:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  logic [ROW_W-1:0]  rs;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [1:0]        cidx_q, cidx_d;
  logic [ROW_W-1:0]  pat_q, pat_d;
  logic [VAL_W-1:0]  value_q, value_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic [1:0]        cidx_nxt;

  sync_2ff #(
    .WIDTH   (ROW_W),
    .RST_VAL (ROW_IDLE)
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (rs)
  );

  assign cidx_nxt = cidx_q + 2'd1;

  // Scan / debounce / release sequencing, key decode and entry-register update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    cidx_d      = cidx_q;
    pat_d       = pat_q;
    value_d     = value_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;

    case (state_q)
      ST_SCAN: begin
        if (col_q == COL_OFF) begin
          // first clock out of reset: start driving column 0
          col_d = COL_TBL[cidx_q];
          cnt_d = '0;
        end else if (cnt_q == SCAN_CNT) begin
          cnt_d = '0;
          if (rs != ROW_IDLE) begin
            pat_d   = rs;
            state_d = ST_DEBOUNCE;
          end else begin
            cidx_d = cidx_nxt;
            col_d  = COL_TBL[cidx_nxt];
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_DEBOUNCE: begin
        if (rs != pat_q) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          cidx_d  = cidx_nxt;
          col_d   = COL_TBL[cidx_nxt];
        end else if (cnt_q == DEBOUNCE_CNT) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          if (single_low(pat_q)) begin
            key_valid_d = 1'b1;
            key_code_d  = {low_index(pat_q), cidx_q};
            value_d     = {value_q[VAL_W-CODE_W-1:0], key_code_d};
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_RELEASE: begin
        if (rs != ROW_IDLE) begin
          cnt_d = '0;
        end else if (cnt_q == DEBOUNCE_CNT) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          cidx_d  = cidx_nxt;
          col_d   = COL_TBL[cidx_nxt];
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase

    // clear wins over a simultaneous digit shift
    if (clr) value_d = '0;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_SCAN;
      cnt_q       <= '0;
      col_q       <= COL_OFF;
      cidx_q      <= 2'd0;
      pat_q       <= ROW_IDLE;
      value_q     <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      cidx_q      <= cidx_d;
      pat_q       <= pat_d;
      value_q     <= value_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign col       = col_q;
  assign value     = value_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule
